qep_decoder: RTL and testbench
==============================

// Module: qep_decoder
// PURPOSE
//  Front-end of the QEP channel, directly upstream of QEPcounter. Synchronises and glitch-filters raw
//  encoder A/B/I pins, decodes quadrature state transitions into count strobes (x4/x2/x1), and drives
//  QEPcounter's pulse/dir/index inputs. Also flags illegal (double-edge) transitions.
// PARAMETERS
//  P_SYNC_STAGES  2   flops in each input synchroniser (>=2)
//  P_FILT_WIDTH   8   width of per-channel stability counter / filt_len
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  qep_a        in   1   raw encoder A (asynchronous to clk)
//  qep_b        in   1   raw encoder B (asynchronous to clk)
//  qep_i        in   1   raw encoder index (asynchronous to clk)
//  filt_len     in   P_FILT_WIDTH  required stable clocks before a filtered channel changes
//  mode         in   2   00=x4, 01=x2, 10=x1, 11=x4
//  swap_ab      in   1   exchange A and B after filtering
//  dir_invert   in   1   invert reported direction
//  index_qual   in   1   1: index valid only while filtered A=B=1
//  err_clear    in   1   clears phase_err and err_count (synchronous, single cycle)
//  pulse        out  1   count strobe to QEPcounter (1-clk high, >=1 clk low between strobes)
//  dir          out  1   direction to QEPcounter, 1 = forward
//  index        out  1   filtered/qualified index level to QEPcounter
//  phase_err    out  1   sticky illegal-transition / overrun flag
//  err_count    out  16  saturating count of error events
// BEHAVIOUR
//  - Reset: all outputs 0; filters, counters, pending flag 0; FSM -> ST_PRIME.
//  - Sync: P_SYNC_STAGES flops per pin, no reset-dependent glitch on outputs.
//  - Filter: filtered bit f changes to synced s only after s!=f for filt_len+1 consecutive clocks;
//    any s==f sample reloads the counter. filt_len=0 -> f follows s with 1 clk delay.
//  - FSM: ST_PRIME: first cycle after reset, latch filtered {A,B} as prev state, no events -> ST_RUN.
//    ST_RUN: compare current vs prev {A,B} each clk; prev updates every clk. No return to PRIME
//    except via reset.
//  - Forward sequence (A leads B) AB: 00->10->11->01->00; reverse is the opposite order.
//  - Single-bit change = valid edge; both bits change in one clk = illegal: no event, error event.
//  - Event qualify: x4 every valid edge; x2 every A edge; x1 only A edge with B=0
//    (forward: A rise, reverse: A fall).
//  - dir updates to (decoded dir ^ dir_invert) in the cycle the strobe is issued; held until next strobe.
//  - Strobe spacing: event while pulse=1 sets pending; pending issues strobe after one low cycle.
//    Event while pending already set = overrun: event dropped, error event.
//  - Error event: phase_err<=1, err_count+1 saturating at 16'hFFFF. err_clear wins over a
//    same-cycle error event (error lost).
//  - index = filtered I & (index_qual ? A&B : 1); latency = sync + filter + 1 register.
//  - Latency pin edge -> pulse: P_SYNC_STAGES + filt_len + 2 clks.
//  - mode/swap_ab changes mid-run take effect next clk; no spurious event since prev state is
//    post-swap {A,B} (swap toggle with A!=B produces one illegal/valid edge; documented, not masked).
// STRUCTURE
//  - qep_pkg: typedef enum qep_mode_t {QEP_X4,QEP_X2,QEP_X1}; typedef enum {ST_PRIME,ST_RUN} qep_st_t;
//    localparam forward-transition lookup table.
//  - Sub-module qep_input_filter (sync chain + stability counter), instantiated for A, B, I.
// TESTING
//  1 x4, filt_len=2, 10 forward cycles (40 edges, 20 clk/edge) -> 40 strobes, dir=1, phase_err=0.
//  2 x1 then x2, same stimulus reversed -> 10 / 20 strobes, dir=0; QEPcounter count decrements
//    by same amount.
//  3 3-clk glitch on A with filt_len=4 -> no strobe; 5-clk stable change -> exactly 1 strobe.
//  4 AB 00->11 in one filtered step -> no strobe, phase_err=1, err_count=1; err_clear -> both 0.
//  5 filt_len=0, A and B edges on consecutive clks x3 -> strobes spaced >=1 low clk, third
//    back-to-back gives overrun err.
//  6 reset with encoder at AB=11, release -> no strobe in PRIME; index_qual=1, I high while
//    A=0 -> index=0.

Source files
------------

// File: rtl/qep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qep_pkg
// Description : Shared types and helpers for the QEP front-end decoder.
//               Covers the count-mode encoding, the decoder state machine
//               states and the forward quadrature transition table.
// Revision    : 1.0  initial release
// ============================================================================
package qep_pkg;

  typedef enum logic [1:0] {
    QEP_X4 = 2'd0,
    QEP_X2 = 2'd1,
    QEP_X1 = 2'd2
  } qep_mode_t;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } qep_st_t;

  // Forward successor of each {A,B} state, indexed by the current state:
  // 00->10, 01->00, 10->11, 11->01 (A leads B).
  localparam logic [7:0] FWD_NEXT = 8'b01_11_00_10;

  function automatic logic is_forward(input logic [1:0] prev, input logic [1:0] cur);
    return FWD_NEXT[{prev, 1'b0} +: 2] == cur;
  endfunction

  // Mode 2'b11 is treated as x4, the same as 2'b00.
  function automatic qep_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return QEP_X2;
      2'b10:   return QEP_X1;
      default: return QEP_X4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/qep_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : qep_input_filter
// Description : Synchroniser chain plus stability-counter glitch filter for
//               one raw encoder pin. The filtered output takes the synced
//               value only after it differs for filt_len+1 consecutive clocks.
// Revision    : 1.0  initial release
// ============================================================================
module qep_input_filter #(
  parameter int P_SYNC_STAGES = 2,
  parameter int P_FILT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    din,
  input  logic [P_FILT_WIDTH-1:0] filt_len,
  output logic                    dout
);

  logic [P_SYNC_STAGES-1:0] sync_q;
  logic [P_FILT_WIDTH-1:0]  cnt_q;
  logic                     filt_q;
  logic                     synced;

  assign synced = sync_q[P_SYNC_STAGES-1];
  assign dout   = filt_q;

  // Synchroniser shift chain for the asynchronous pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[P_SYNC_STAGES-2:0], din};
  end

  // Stability counter: any agreeing sample reloads; a full run of
  // disagreeing samples commits the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (synced == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == filt_len) begin
      cnt_q  <= '0;
      filt_q <= synced;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/qep_decoder.sv
`default_nettype none
// ============================================================================
// Module      : qep_decoder
// Description : QEP channel front-end. Filters A/B/I, decodes quadrature
//               transitions into spaced count strobes with direction, drives
//               the qualified index level and tracks illegal/overrun errors.
// Revision    : 1.0  initial release
// ============================================================================
module qep_decoder
  import qep_pkg::*;
#(
  parameter int P_SYNC_STAGES = 2,
  parameter int P_FILT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    qep_a,
  input  logic                    qep_b,
  input  logic                    qep_i,
  input  logic [P_FILT_WIDTH-1:0] filt_len,
  input  logic [1:0]              mode,
  input  logic                    swap_ab,
  input  logic                    dir_invert,
  input  logic                    index_qual,
  input  logic                    err_clear,
  output logic                    pulse,
  output logic                    dir,
  output logic                    index,
  output logic                    phase_err,
  output logic [15:0]             err_count
);

  logic      filt_a, filt_b, filt_i;
  logic [1:0] cur_ab, prev_q, diff;
  qep_st_t   state_q, state_d;
  qep_mode_t mode_dec;
  logic      ev, ev_dir, illegal, overrun, pending_q, pend_dir_q;

  qep_input_filter #(.P_SYNC_STAGES(P_SYNC_STAGES), .P_FILT_WIDTH(P_FILT_WIDTH)) u_filt_a (
    .clk(clk), .reset(reset), .din(qep_a), .filt_len(filt_len), .dout(filt_a));
  qep_input_filter #(.P_SYNC_STAGES(P_SYNC_STAGES), .P_FILT_WIDTH(P_FILT_WIDTH)) u_filt_b (
    .clk(clk), .reset(reset), .din(qep_b), .filt_len(filt_len), .dout(filt_b));
  qep_input_filter #(.P_SYNC_STAGES(P_SYNC_STAGES), .P_FILT_WIDTH(P_FILT_WIDTH)) u_filt_i (
    .clk(clk), .reset(reset), .din(qep_i), .filt_len(filt_len), .dout(filt_i));

  // Swap is applied after filtering, so prev always holds post-swap {A,B}.
  assign cur_ab = swap_ab ? {filt_b, filt_a} : {filt_a, filt_b};
  assign diff   = cur_ab ^ prev_q;

  // State register and previous {A,B} snapshot (refreshed every clock).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_PRIME;
      prev_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      prev_q  <= cur_ab;
    end
  end

  // Next state plus transition decode and mode qualification.
  always_comb begin
    state_d  = state_q;
    ev       = 1'b0;
    ev_dir   = 1'b0;
    illegal  = 1'b0;
    mode_dec = decode_mode(mode);
    case (state_q)
      ST_PRIME: state_d = ST_RUN;
      ST_RUN: begin
        if (diff == 2'b11) begin
          illegal = 1'b1;
        end else if (diff != 2'b00) begin
          ev_dir = is_forward(prev_q, cur_ab);
          case (mode_dec)
            QEP_X2:  ev = diff[1];
            QEP_X1:  ev = diff[1] & ~cur_ab[0];
            default: ev = 1'b1;
          endcase
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  assign overrun = ev & (pulse | pending_q) & pending_q;

  // Strobe generator: guarantees a low cycle between strobes, with a
  // single-deep pending slot for events that land on a high cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse      <= 1'b0;
      dir        <= 1'b0;
      pending_q  <= 1'b0;
      pend_dir_q <= 1'b0;
    end else if (pulse) begin
      pulse <= 1'b0;
      if (ev && !pending_q) begin
        pending_q  <= 1'b1;
        pend_dir_q <= ev_dir;
      end
    end else if (pending_q) begin
      pulse     <= 1'b1;
      dir       <= pend_dir_q ^ dir_invert;
      pending_q <= 1'b0;
    end else if (ev) begin
      pulse <= 1'b1;
      dir   <= ev_dir ^ dir_invert;
    end
  end

  // Sticky error flag and saturating error counter; clear has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_err <= 1'b0;
      err_count <= 16'h0000;
    end else if (err_clear) begin
      phase_err <= 1'b0;
      err_count <= 16'h0000;
    end else if (illegal || overrun) begin
      phase_err <= 1'b1;
      if (err_count != 16'hFFFF) err_count <= err_count + 16'h0001;
    end
  end

  // Registered index level, optionally gated by A=B=1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) index <= 1'b0;
    else       index <= filt_i & (index_qual ? (cur_ab == 2'b11) : 1'b1);
  end

endmodule
`default_nettype wire

// File: tb/tb_qep_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_qep_decoder
// Description : Self-checking bench for qep_decoder: table-driven quadrature
//               runs plus directed latency, glitch, illegal-step, overrun,
//               reset-priming and index-qualification sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_qep_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        qep_a = 1'b0, qep_b = 1'b0, qep_i = 1'b0;
  logic [7:0]  filt_len = 8'd2;
  logic [1:0]  mode = 2'b00;
  logic        swap_ab = 1'b0, dir_invert = 1'b0, index_qual = 1'b0, err_clear = 1'b0;
  logic        pulse, dir, index, phase_err;
  logic [15:0] err_count;

  int errors = 0;
  int checks = 0;

  qep_decoder #(.P_SYNC_STAGES(2), .P_FILT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .qep_a(qep_a), .qep_b(qep_b), .qep_i(qep_i),
    .filt_len(filt_len), .mode(mode), .swap_ab(swap_ab), .dir_invert(dir_invert),
    .index_qual(index_qual), .err_clear(err_clear), .pulse(pulse), .dir(dir),
    .index(index), .phase_err(phase_err), .err_count(err_count));

  always #5 clk = ~clk;

  // Strobe monitor: counts strobes, records their direction, flags adjacency.
  logic clr_req = 1'b0;
  int   pcount = 0;
  int   spc_viol = 0;
  logic last_dir = 1'b0;
  logic prev_p = 1'b0;
  always @(posedge clk) begin
    if (clr_req) begin
      pcount   <= 0;
      spc_viol <= 0;
      last_dir <= 1'b0;
      prev_p   <= 1'b0;
    end else begin
      prev_p <= pulse;
      if (pulse) begin
        pcount   <= pcount + 1;
        last_dir <= dir;
        if (prev_p) spc_viol <= spc_viol + 1;
      end
    end
  end

  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] pos = 2'd0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    clr_req = 1'b1;
    tick(1);
    clr_req = 1'b0;
  endtask

  task automatic step(input bit fwd);
    pos = fwd ? pos + 2'd1 : pos - 2'd1;
    {qep_a, qep_b} = seq[pos];
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pulse"}, int'(pulse), 0);
    check({tag, "_dir"}, int'(dir), 0);
    check({tag, "_index"}, int'(index), 0);
    check({tag, "_phase_err"}, int'(phase_err), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
  endtask

  typedef struct {
    logic [1:0] mode;
    bit         fwd;
    bit         inv;
    int         exp_pulses;
    bit         exp_dir;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int  k;
    bit  found;

    vecs[0] = '{2'b00, 1'b1, 1'b0, 40, 1'b1};
    vecs[1] = '{2'b10, 1'b0, 1'b0, 10, 1'b0};
    vecs[2] = '{2'b01, 1'b0, 1'b0, 20, 1'b0};
    vecs[3] = '{2'b00, 1'b0, 1'b1, 40, 1'b1};
    vecs[4] = '{2'b10, 1'b1, 1'b0, 10, 1'b1};
    vecs[5] = '{2'b11, 1'b1, 1'b0, 40, 1'b1};

    tick(3);
    check_reset_state("reset");
    reset = 1'b0;
    tick(10);

    // Table: 10 full encoder cycles per row, 20 clocks per edge.
    for (int v = 0; v < 6; v++) begin
      mode       = vecs[v].mode;
      dir_invert = vecs[v].inv;
      tick(10);
      clr();
      repeat (40) begin
        step(vecs[v].fwd);
        tick(20);
      end
      tick(20);
      check($sformatf("row%0d_pulses", v), pcount, vecs[v].exp_pulses);
      check($sformatf("row%0d_dir", v), int'(last_dir), int'(vecs[v].exp_dir));
      check($sformatf("row%0d_phase_err", v), int'(phase_err), 0);
      check($sformatf("row%0d_spacing", v), spc_viol, 0);
    end
    mode = 2'b00;
    dir_invert = 1'b0;

    // Pin edge to strobe latency: sync(2) + filt_len(2) + 2 = 6 clocks.
    clr();
    step(1'b1);
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (pulse) found = 1'b1;
    end
    check("latency", k, 6);
    tick(20);
    step(1'b0);
    tick(20);

    // Glitch filter with filt_len=4: 3-clk glitch rejected, 5-clk change accepted.
    filt_len = 8'd4;
    tick(5);
    clr();
    qep_a = 1'b1;
    tick(3);
    qep_a = 1'b0;
    tick(30);
    check("glitch_pulses", pcount, 0);
    qep_a = 1'b1;
    tick(5);
    tick(30);
    check("stable_pulses", pcount, 1);
    check("stable_dir", int'(last_dir), 1);
    qep_a = 1'b0;
    tick(30);

    // Illegal double-edge 00->11, then clear; then clear overlapping an error.
    filt_len = 8'd2;
    tick(5);
    clr();
    qep_a = 1'b1;
    qep_b = 1'b1;
    tick(30);
    check("illegal_pulses", pcount, 0);
    check("illegal_phase_err", int'(phase_err), 1);
    check("illegal_err_count", int'(err_count), 1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(2);
    check("clear_phase_err", int'(phase_err), 0);
    check("clear_err_count", int'(err_count), 0);
    err_clear = 1'b1;
    qep_a = 1'b0;
    qep_b = 1'b0;
    tick(30);
    err_clear = 1'b0;
    tick(2);
    check("clear_wins_phase_err", int'(phase_err), 0);
    check("clear_wins_err_count", int'(err_count), 0);
    check("clear_wins_pulses", pcount, 0);
    pos = 2'd0;

    // Back-to-back edges with filt_len=0: two spaced strobes, third overruns.
    filt_len = 8'd0;
    tick(5);
    clr();
    step(1'b1);
    tick(1);
    step(1'b1);
    tick(1);
    step(1'b1);
    tick(20);
    check("overrun_pulses", pcount, 2);
    check("overrun_spacing", spc_viol, 0);
    check("overrun_dir", int'(last_dir), 1);
    check("overrun_phase_err", int'(phase_err), 1);
    check("overrun_err_count", int'(err_count), 1);

    // Reset with encoder parked at AB=11 and index high.
    filt_len   = 8'd2;
    index_qual = 1'b1;
    qep_a = 1'b1;
    qep_b = 1'b1;
    qep_i = 1'b1;
    reset = 1'b1;
    tick(3);
    check_reset_state("reset2");
    reset = 1'b0;
    clr();
    tick(30);
    check("prime_pulses", pcount, 0);
    check("index_qual_ab11", int'(index), 1);
    qep_a = 1'b0;
    tick(20);
    check("index_qual_a0", int'(index), 0);
    index_qual = 1'b0;
    tick(5);
    check("index_unqual_a0", int'(index), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
